fcl_operand_packer: RTL and testbench

Producer-side feeder for the 5-pair multiply-add stage of fully-connected layer 1. It accepts one (activation, weight) operand pair per beat on a valid/ready stream. It packs the pairs into the five packed operand buses a..e, where element [0] is the activation and element [1] is the weight. Each complete bundle is presented to the MAC stage with valid/last, and the final partial group of a vector is zero-padded.

---
 rtl/fcl_operand_packer.sv | 152 +++++++++++++++
 tb/tb_fcl_operand_packer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcl_operand_packer.sv
// fcl_operand_packer
// Packs (activation, weight) beats into five-slot bundles for the FC1
// multiply-add stage. Element [0] of each slot is the activation and element
// [1] is the weight. The final partial group of a vector is zero-padded, so
// unused slots add nothing to the downstream sum.
module fcl_operand_packer #(
    parameter int OPERAND_WIDTH = 8,
    parameter int PAIR          = 2,
    parameter int LEN_WIDTH     = 10
) (
    input  logic                                 pack_clk,
    input  logic                                 pack_rst,
    input  logic                                 pack_start_i,
    input  logic [LEN_WIDTH-1:0]                 pack_len_i,
    input  logic                                 pack_in_valid_i,
    input  logic [OPERAND_WIDTH-1:0]             pack_in_act_i,
    input  logic [OPERAND_WIDTH-1:0]             pack_in_wgt_i,
    output logic                                 pack_in_ready_o,
    output logic [PAIR-1:0][OPERAND_WIDTH-1:0]   pack_out_a_o,
    output logic [PAIR-1:0][OPERAND_WIDTH-1:0]   pack_out_b_o,
    output logic [PAIR-1:0][OPERAND_WIDTH-1:0]   pack_out_c_o,
    output logic [PAIR-1:0][OPERAND_WIDTH-1:0]   pack_out_d_o,
    output logic [PAIR-1:0][OPERAND_WIDTH-1:0]   pack_out_e_o,
    output logic                                 pack_out_valid_o,
    output logic                                 pack_out_last_o,
    input  logic                                 pack_out_ready_i,
    output logic                                 pack_busy_o,
    output logic                                 pack_done_o
);

    localparam int SLOTS    = 5;
    localparam int BUNDLE_W = SLOTS * PAIR * OPERAND_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    typedef logic [PAIR-1:0][OPERAND_WIDTH-1:0] slot_t;

    state_t                   state_r;
    slot_t [SLOTS-1:0]        slot_r;
    logic  [2:0]              index_r;
    logic  [LEN_WIDTH-1:0]    remaining_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     out_last_r;
    logic                     busy_r;
    logic                     done_r;

    logic                     in_fire_s;
    logic                     out_fire_s;
    logic                     group_full_s;
    logic                     final_beat_s;
    logic [LEN_WIDTH-1:0]     remaining_dec_s;

    // Handshake qualifiers and end-of-group detection for the beat in flight
    always_comb begin
        in_fire_s       = pack_in_valid_i && in_ready_r;
        out_fire_s      = out_valid_r && pack_out_ready_i;
        remaining_dec_s = remaining_r - LEN_WIDTH'(1);
        group_full_s    = (index_r == 3'd4);
        final_beat_s    = (remaining_r == LEN_WIDTH'(1));
    end

    // Packer FSM: all handshake/status outputs are registered alongside state
    always_ff @(posedge pack_clk or posedge pack_rst) begin
        if (pack_rst) begin
            state_r     <= ST_IDLE;
            slot_r      <= {BUNDLE_W{1'b0}};
            index_r     <= 3'd0;
            remaining_r <= {LEN_WIDTH{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pack_start_i) begin
                        if (pack_len_i != {LEN_WIDTH{1'b0}}) begin
                            remaining_r <= pack_len_i;
                            slot_r      <= {BUNDLE_W{1'b0}};
                            index_r     <= 3'd0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_FILL;
                        end else begin
                            // Empty vector: acknowledge without emitting a bundle
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_fire_s) begin
                        slot_r[index_r] <= {pack_in_wgt_i, pack_in_act_i};
                        index_r         <= index_r + 3'd1;
                        remaining_r     <= remaining_dec_s;
                        if (group_full_s || final_beat_s) begin
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= final_beat_s;
                            state_r     <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                        if (out_last_r) begin
                            out_last_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            slot_r     <= {BUNDLE_W{1'b0}};
                            index_r    <= 3'd0;
                            in_ready_r <= 1'b1;
                            state_r    <= ST_FILL;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle state
                    state_r     <= ST_IDLE;
                    slot_r      <= {BUNDLE_W{1'b0}};
                    index_r     <= 3'd0;
                    remaining_r <= {LEN_WIDTH{1'b0}};
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pack_in_ready_o  = in_ready_r;
    assign pack_out_valid_o = out_valid_r;
    assign pack_out_last_o  = out_last_r;
    assign pack_busy_o      = busy_r;
    assign pack_done_o      = done_r;
    assign pack_out_a_o     = slot_r[0];
    assign pack_out_b_o     = slot_r[1];
    assign pack_out_c_o     = slot_r[2];
    assign pack_out_d_o     = slot_r[3];
    assign pack_out_e_o     = slot_r[4];

endmodule

// File: tb/tb_fcl_operand_packer.sv
// Self-checking bench for fcl_operand_packer. Inputs are driven and outputs
// sampled on the falling edge; a bundle model chunks the accepted beats into
// groups of five with zero padding.
module tb_fcl_operand_packer;

    typedef struct packed {
        logic                  last;
        logic [4:0][1:0][7:0]  slots;
    } bundle_t;

    logic                   pack_clk = 1'b0;
    logic                   pack_rst;
    logic                   pack_start_i;
    logic [9:0]             pack_len_i;
    logic                   pack_in_valid_i;
    logic [7:0]             pack_in_act_i;
    logic [7:0]             pack_in_wgt_i;
    logic                   pack_in_ready_o;
    logic [1:0][7:0]        pack_out_a_o, pack_out_b_o, pack_out_c_o, pack_out_d_o, pack_out_e_o;
    logic                   pack_out_valid_o;
    logic                   pack_out_last_o;
    logic                   pack_out_ready_i;
    logic                   pack_busy_o;
    logic                   pack_done_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] act_q[$];
    logic [7:0] wgt_q[$];
    bundle_t    obs_q[$];
    bundle_t    exp_q[$];
    int         done_q[$];
    int         hs_neg;

    fcl_operand_packer #(.OPERAND_WIDTH(8), .PAIR(2), .LEN_WIDTH(10)) dut (
        .pack_clk         (pack_clk),
        .pack_rst         (pack_rst),
        .pack_start_i     (pack_start_i),
        .pack_len_i       (pack_len_i),
        .pack_in_valid_i  (pack_in_valid_i),
        .pack_in_act_i    (pack_in_act_i),
        .pack_in_wgt_i    (pack_in_wgt_i),
        .pack_in_ready_o  (pack_in_ready_o),
        .pack_out_a_o     (pack_out_a_o),
        .pack_out_b_o     (pack_out_b_o),
        .pack_out_c_o     (pack_out_c_o),
        .pack_out_d_o     (pack_out_d_o),
        .pack_out_e_o     (pack_out_e_o),
        .pack_out_valid_o (pack_out_valid_o),
        .pack_out_last_o  (pack_out_last_o),
        .pack_out_ready_i (pack_out_ready_i),
        .pack_busy_o      (pack_busy_o),
        .pack_done_o      (pack_done_o)
    );

    always #5 pack_clk = ~pack_clk;

    function automatic bundle_t capture();
        bundle_t b;
        b.last     = pack_out_last_o;
        b.slots[0] = pack_out_a_o;
        b.slots[1] = pack_out_b_o;
        b.slots[2] = pack_out_c_o;
        b.slots[3] = pack_out_d_o;
        b.slots[4] = pack_out_e_o;
        return b;
    endfunction

    // Reference: beats in order, five per bundle, missing slots zero, last on final bundle
    function automatic void model_bundles(input int len);
        int nb;
        bundle_t b;
        exp_q.delete();
        nb = (len + 4) / 5;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 5; j++) begin
                if (5 * k + j < len) begin
                    b.slots[j][0] = act_q[5 * k + j];
                    b.slots[j][1] = wgt_q[5 * k + j];
                end
            end
            b.last = (k == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic fill_random(input int len);
        act_q.delete();
        wgt_q.delete();
        for (int i = 0; i < len; i++) begin
            act_q.push_back(8'($urandom));
            wgt_q.push_back(8'($urandom));
        end
    endtask

    // Stimulus driver: vmode 0=always valid, 1=every other cycle, 2=random;
    // rmode 0=always ready, 1=random. restart_at pulses start (len 3) mid-vector.
    task automatic run_vec(input int len, input int vmode, input int rmode, input int restart_at);
        int bi;
        obs_q.delete();
        done_q.delete();
        hs_neg = -10;
        bi = 0;
        @(negedge pack_clk);
        pack_start_i = 1'b1;
        pack_len_i   = 10'(len);
        @(negedge pack_clk);
        pack_start_i = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (pack_done_o) done_q.push_back(n);
            if (done_q.size() > 0 && n >= done_q[0] + 2) break;
            pack_start_i     = (n == restart_at);
            pack_len_i       = (n == restart_at) ? 10'd3 : 10'(len);
            pack_out_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom);
            if (bi < len) begin
                pack_in_valid_i = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : 1'($urandom);
                pack_in_act_i   = act_q[bi];
                pack_in_wgt_i   = wgt_q[bi];
            end else begin
                pack_in_valid_i = 1'($urandom);
                pack_in_act_i   = 8'($urandom);
                pack_in_wgt_i   = 8'($urandom);
            end
            if (pack_in_valid_i && pack_in_ready_o) bi++;
            if (pack_out_valid_o && pack_out_ready_i) begin
                obs_q.push_back(capture());
                hs_neg = n;
            end
            @(negedge pack_clk);
        end
        pack_in_valid_i  = 1'b0;
        pack_start_i     = 1'b0;
    endtask

    task automatic test_reset();
        pack_rst = 1'b1;
        repeat (3) @(negedge pack_clk);
        checks++;
        if ({pack_in_ready_o, pack_out_valid_o, pack_out_last_o, pack_busy_o, pack_done_o} !== 5'b0 ||
            {pack_out_a_o, pack_out_b_o, pack_out_c_o, pack_out_d_o, pack_out_e_o} !== 80'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b slots=%h, expected all zero",
                     {pack_in_ready_o, pack_out_valid_o, pack_out_last_o, pack_busy_o, pack_done_o},
                     {pack_out_a_o, pack_out_b_o, pack_out_c_o, pack_out_d_o, pack_out_e_o});
        end
        pack_rst = 1'b0;
        @(negedge pack_clk);
    endtask

    task automatic test_basic();
        act_q = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
        wgt_q = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10};
        run_vec(5, 0, 0, -1);
        model_bundles(5);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d bundles, expected 1", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_bundle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].slots[0] !== 16'h0201 || obs_q[0].slots[4] !== 16'h0a09) begin
                errors++; $display("FAIL basic_slot_order: got a=%h e=%h expected a=0201 e=0a09",
                                   obs_q[0].slots[0], obs_q[0].slots[4]);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != hs_neg + 1) begin
            errors++; $display("FAIL basic_done: got %0d pulses first at %0d, expected 1 at %0d",
                               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, hs_neg + 1);
        end
    endtask

    task automatic test_padding();
        act_q.delete(); wgt_q.delete();
        for (int i = 0; i < 7; i++) begin act_q.push_back(8'hcc); wgt_q.push_back(8'haa); end
        run_vec(7, 0, 0, -1);
        model_bundles(7);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL pad_count: got %0d bundles, expected 2", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL pad_bundle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 2) begin
            checks++;
            if (obs_q[0].last !== 1'b0 || obs_q[1].last !== 1'b1 || obs_q[1].slots[4:2] !== 48'h0) begin
                errors++; $display("FAIL pad_last_zero: got last=%b%b cde=%h expected last=01 cde=0",
                                   obs_q[0].last, obs_q[1].last, obs_q[1].slots[4:2]);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != hs_neg + 1) begin
            errors++; $display("FAIL pad_done: got %0d pulses, expected 1 at %0d", done_q.size(), hs_neg + 1);
        end
    endtask

    task automatic test_stall();
        bundle_t held;
        int bi, vcount;
        fill_random(5);
        model_bundles(5);
        bi = 0; vcount = 0;
        held = '0;
        pack_out_ready_i = 1'b0;
        @(negedge pack_clk);
        pack_start_i = 1'b1; pack_len_i = 10'd5;
        @(negedge pack_clk);
        pack_start_i = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (pack_out_valid_o) begin
                vcount++;
                if (vcount == 1) held = capture();
                else begin
                    checks++;
                    if (capture() !== held) begin
                        errors++; $display("FAIL stall_hold: got %h expected %h", capture(), held);
                    end
                end
                checks++;
                if (pack_in_ready_o !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready: got %b expected 0", pack_in_ready_o);
                end
                if (vcount == 5) begin
                    pack_out_ready_i = 1'b1;
                    break;
                end
            end
            pack_in_valid_i = (bi < 5);
            pack_in_act_i   = (bi < 5) ? act_q[bi] : 8'h00;
            pack_in_wgt_i   = (bi < 5) ? wgt_q[bi] : 8'h00;
            if (pack_in_valid_i && pack_in_ready_o) bi++;
            @(negedge pack_clk);
        end
        pack_in_valid_i = 1'b0;
        checks++;
        if (vcount != 5 || held !== exp_q[0]) begin
            errors++; $display("FAIL stall_bundle: got %0d valid cycles bundle %h, expected 5 and %h",
                               vcount, held, exp_q[0]);
        end
        @(negedge pack_clk);
        checks++;
        if (pack_done_o !== 1'b1 || pack_out_valid_o !== 1'b0) begin
            errors++; $display("FAIL stall_done: got done=%b valid=%b expected done=1 valid=0",
                               pack_done_o, pack_out_valid_o);
        end
        @(negedge pack_clk);
        checks++;
        if (pack_done_o !== 1'b0) begin
            errors++; $display("FAIL stall_done_width: got done=%b expected 0", pack_done_o);
        end
    endtask

    task automatic test_toggle();
        fill_random(10);
        run_vec(10, 1, 0, -1);
        model_bundles(10);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL toggle_count: got %0d bundles, expected 2", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL toggle_bundle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        fill_random(5);
        run_vec(5, 0, 0, 2);
        model_bundles(5);
        checks++;
        if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
            errors++; $display("FAIL restart_ignored: got %0d bundles first %h, expected 1 of %h",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != hs_neg + 1) begin
            errors++; $display("FAIL restart_done: got %0d pulses, expected 1 at %0d", done_q.size(), hs_neg + 1);
        end
        act_q.delete(); wgt_q.delete();
        run_vec(0, 0, 0, -1);
        checks++;
        if (obs_q.size() != 0 || done_q.size() != 1 || done_q[0] != 0) begin
            errors++; $display("FAIL len0: got %0d bundles %0d done pulses, expected 0 bundles 1 pulse at 0",
                               obs_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        fill_random(3);
        pack_out_ready_i = 1'b1;
        @(negedge pack_clk);
        pack_start_i = 1'b1; pack_len_i = 10'd5;
        @(negedge pack_clk);
        pack_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pack_in_valid_i = 1'b1;
            pack_in_act_i = act_q[i];
            pack_in_wgt_i = wgt_q[i];
            @(negedge pack_clk);
        end
        pack_in_valid_i = 1'b0;
        checks++;
        if (pack_busy_o !== 1'b1 || pack_out_a_o === 16'h0000 && act_q[0] != 8'h00) begin
            errors++; $display("FAIL midrst_pre: got busy=%b a=%h expected busy=1 a=%h%h",
                               pack_busy_o, pack_out_a_o, 8'h00, act_q[0]);
        end
        #2 pack_rst = 1'b1;
        #1;
        checks++;
        if ({pack_in_ready_o, pack_out_valid_o, pack_out_last_o, pack_busy_o, pack_done_o} !== 5'b0 ||
            {pack_out_a_o, pack_out_b_o, pack_out_c_o} !== 48'h0) begin
            errors++; $display("FAIL midrst_zero: got ctl=%b abc=%h expected zero",
                               {pack_in_ready_o, pack_out_valid_o, pack_out_last_o, pack_busy_o, pack_done_o},
                               {pack_out_a_o, pack_out_b_o, pack_out_c_o});
        end
        @(negedge pack_clk);
        pack_rst = 1'b0;
        done_seen = 0;
        repeat (3) begin
            @(negedge pack_clk);
            if (pack_done_o || pack_busy_o) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++; $display("FAIL midrst_nodone: got %0d cycles with done/busy, expected 0", done_seen);
        end
        act_q = '{8'h11};
        wgt_q = '{8'h22};
        run_vec(1, 0, 0, -1);
        checks++;
        if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== {1'b1, 64'h0, 16'h2211})) begin
            errors++; $display("FAIL midrst_len1: got %0d bundles first %h, expected 1 of %h",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, {1'b1, 64'h0, 16'h2211});
        end
    endtask

    task automatic test_random();
        int len;
        for (int v = 0; v < 8; v++) begin
            len = $urandom_range(1, 23);
            fill_random(len);
            run_vec(len, 2, 1, -1);
            model_bundles(len);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d bundles, expected %0d (len %0d)",
                                   v, obs_q.size(), exp_q.size(), len);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_bundle%0d: got %h expected %h", v, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] != hs_neg + 1) begin
                errors++; $display("FAIL rand%0d_done: got %0d pulses, expected 1 at %0d",
                                   v, done_q.size(), hs_neg + 1);
            end
        end
    endtask

    initial begin
        pack_rst         = 1'b1;
        pack_start_i     = 1'b0;
        pack_len_i       = 10'd0;
        pack_in_valid_i  = 1'b0;
        pack_in_act_i    = 8'h00;
        pack_in_wgt_i    = 8'h00;
        pack_out_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_padding();
        test_stall();
        test_toggle();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
